// File: rtl/transform_host_master.sv
// transform_host_master
// Bus master that configures a transform engine, waits for its interrupt,
// reads NUM_WORDS result words onto a valid/ready stream, then clears the
// interrupt status and pulses out_done.
// Optional feature: define HOST_TIMEOUT_EN to bound the interrupt wait by
// TIMEOUT cycles; on expiry the block parks in ERR with out_error=1 until reset.
module transform_host_master #(
   parameter int unsigned NUM_WORDS = 16,
   parameter logic [31:0] CTRL_ADDR = 32'h0000_0000,
   parameter logic [31:0] STAT_ADDR = 32'h0000_0004,
   parameter logic [31:0] RES_BASE  = 32'h0000_1000,
   parameter logic [31:0] IDLE_ADDR = 32'hFFFF_FFFC,
   parameter int unsigned TIMEOUT   = 4096
) (
   input  logic        in_HCLK,
   input  logic        in_HRESET,
   input  logic        in_start,
   input  logic [31:0] in_cfg_word,
   output logic [31:0] out_HADDR,
   output logic        out_HWRITE,
   output logic [31:0] out_HWDATA,
   input  logic        in_HREADY,
   input  logic [31:0] in_HRDATA,
   input  logic        in_interrupt,
   output logic [31:0] out_data,
   output logic        out_data_valid,
   input  logic        in_data_ready,
   output logic        out_busy,
   output logic        out_done,
   output logic        out_error
);

   // Index wide enough to hold NUM_WORDS itself, so it never wraps.
   localparam int unsigned    IW       = $clog2(NUM_WORDS + 1);
   localparam logic [IW-1:0]  LAST_IDX = IW'(NUM_WORDS - 1);

   if (NUM_WORDS == 0 || NUM_WORDS > 1024 || TIMEOUT == 0) begin : g_bad_params
      $error("transform_host_master: NUM_WORDS must be 1..1024 and TIMEOUT >= 1");
   end

   typedef enum logic [2:0] {
      IDLE,
      WR_CFG,
      WAIT_IRQ,
      RD_WORD,
      PUSH,
      CLR_IRQ,
      DONE,
      ERR
   } state_t;

   state_t        state;
   logic [IW-1:0] idx;
   logic [IW-1:0] idx_next;

`ifdef HOST_TIMEOUT_EN
   localparam int unsigned   TW      = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT - 1);
   logic [TW-1:0] wait_cnt;
`else
   assign out_error = 1'b0;
`endif

   // Next word index, shared by the address computation and the index update.
   always_comb begin
      idx_next = idx + IW'(1);
   end

   // Control FSM; every bus and stream output is registered alongside the state.
   always_ff @(posedge in_HCLK or negedge in_HRESET) begin
      if (!in_HRESET) begin
         state          <= IDLE;
         idx            <= '0;
         out_HADDR      <= IDLE_ADDR;
         out_HWRITE     <= 1'b0;
         out_HWDATA     <= '0;
         out_data       <= '0;
         out_data_valid <= 1'b0;
         out_busy       <= 1'b0;
         out_done       <= 1'b0;
`ifdef HOST_TIMEOUT_EN
         wait_cnt       <= '0;
         out_error      <= 1'b0;
`endif
      end else begin
         out_done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_start) begin
                  state      <= WR_CFG;
                  out_busy   <= 1'b1;
                  out_HADDR  <= CTRL_ADDR;
                  out_HWRITE <= 1'b1;
                  out_HWDATA <= in_cfg_word | 32'h1;
               end
            end
            WR_CFG: begin
               if (in_HREADY) begin
                  state      <= WAIT_IRQ;
                  out_HADDR  <= IDLE_ADDR;
                  out_HWRITE <= 1'b0;
                  out_HWDATA <= '0;
`ifdef HOST_TIMEOUT_EN
                  wait_cnt   <= '0;
`endif
               end
            end
            WAIT_IRQ: begin
               if (in_interrupt) begin
                  state     <= RD_WORD;
                  idx       <= '0;
                  out_HADDR <= RES_BASE;
               end
`ifdef HOST_TIMEOUT_EN
               else if (wait_cnt == TO_LAST) begin
                  state     <= ERR;
                  out_error <= 1'b1;
               end else begin
                  wait_cnt <= wait_cnt + TW'(1);
               end
`endif
            end
            RD_WORD: begin
               if (in_HREADY) begin
                  state          <= PUSH;
                  out_data       <= in_HRDATA;
                  out_data_valid <= 1'b1;
                  out_HADDR      <= IDLE_ADDR;
               end
            end
            PUSH: begin
               if (in_data_ready) begin
                  out_data_valid <= 1'b0;
                  if (idx < LAST_IDX) begin
                     state     <= RD_WORD;
                     idx       <= idx_next;
                     out_HADDR <= RES_BASE + (32'(idx_next) << 2);
                  end else begin
                     state      <= CLR_IRQ;
                     out_HADDR  <= STAT_ADDR;
                     out_HWRITE <= 1'b1;
                     out_HWDATA <= 32'h1;
                  end
               end
            end
            CLR_IRQ: begin
               if (in_HREADY) begin
                  state      <= DONE;
                  out_done   <= 1'b1;
                  out_HADDR  <= IDLE_ADDR;
                  out_HWRITE <= 1'b0;
                  out_HWDATA <= '0;
               end
            end
            DONE: begin
               state    <= IDLE;
               out_busy <= 1'b0;
            end
`ifdef HOST_TIMEOUT_EN
            ERR: begin
               state <= ERR;
            end
`endif
            default: begin
               state    <= IDLE;
               out_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule
